// File: rtl/uart_cmd_engine.sv
// Host command engine: parses UART 'W'/'R'/'?' commands, drives the memory
// override port and returns response bytes through the TX handshake.
module uart_cmd_engine #(
  parameter int MEM_LATENCY = 1,
  parameter int TIMEOUT     = 2700000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byteReady,
  input  logic [7:0]  dataIn,
  output logic        byteReadyOut,
  output logic [7:0]  dataOut,
  input  logic        byteSending,
  output logic        overrideMemControl,
  output logic        overrideMemRnW,
  output logic [15:0] overrideMemAddr,
  output logic [15:0] overrideMemDataIn,
  input  logic [15:0] overrideMemDataOut
);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, MEM, TX_REQ, TX_WAIT
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int MW = $clog2(MEM_LATENCY + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [MW-1:0] MEM_LAST     = MW'(MEM_LATENCY);

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_PING = 8'h3F;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_PING = 8'h4D;

  state_t          stateReg, stateNext;
  logic            isWriteReg;
  logic            respPendingReg;
  logic [15:0]     addrReg;
  logic [15:0]     dataReg;
  logic [7:0]      rdLowReg;
  logic [7:0]      dataOutReg;
  logic [TW-1:0]   timeoutCntReg;
  logic [MW-1:0]   memCntReg;

  logic parsing, timedOut, memLast;

  assign parsing  = (stateReg == ADDR_H) || (stateReg == ADDR_L) ||
                    (stateReg == DATA_H) || (stateReg == DATA_L);
  // A byte landing on the timeout cycle wins over the abort.
  assign timedOut = parsing && !byteReady && (timeoutCntReg == TIMEOUT_LAST);
  assign memLast  = (memCntReg == MEM_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (byteReady) begin
          if (dataIn == CMD_W || dataIn == CMD_R) stateNext = ADDR_H;
          else if (dataIn == CMD_PING)            stateNext = TX_REQ;
        end
      end
      ADDR_H:  if (timedOut) stateNext = IDLE; else if (byteReady) stateNext = ADDR_L;
      ADDR_L:  if (timedOut) stateNext = IDLE;
               else if (byteReady) stateNext = isWriteReg ? DATA_H : MEM;
      DATA_H:  if (timedOut) stateNext = IDLE; else if (byteReady) stateNext = DATA_L;
      DATA_L:  if (timedOut) stateNext = IDLE; else if (byteReady) stateNext = MEM;
      MEM:     if (memLast) stateNext = TX_REQ;
      TX_REQ:  if (byteSending) stateNext = TX_WAIT;
      TX_WAIT: if (!byteSending) stateNext = respPendingReg ? TX_REQ : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isWriteReg     <= 1'b0;
      respPendingReg <= 1'b0;
      addrReg        <= '0;
      dataReg        <= '0;
      rdLowReg       <= '0;
      dataOutReg     <= '0;
      timeoutCntReg  <= '0;
      memCntReg      <= '0;
    end else begin
      if (!parsing || byteReady) timeoutCntReg <= '0;
      else                       timeoutCntReg <= timeoutCntReg + 1'b1;

      if (stateReg == MEM) memCntReg <= memCntReg + 1'b1;
      else                 memCntReg <= '0;

      case (stateReg)
        IDLE: begin
          if (byteReady) begin
            isWriteReg     <= (dataIn == CMD_W);
            respPendingReg <= 1'b0;
            if (dataIn == CMD_PING) dataOutReg <= RSP_PING;
          end
        end
        ADDR_H: if (byteReady) addrReg[15:8] <= dataIn;
        ADDR_L: if (byteReady) addrReg[7:0]  <= dataIn;
        DATA_H: if (byteReady) dataReg[15:8] <= dataIn;
        DATA_L: if (byteReady) dataReg[7:0]  <= dataIn;
        MEM: begin
          if (memLast) begin
            if (isWriteReg) begin
              dataOutReg <= RSP_OK;
            end else begin
              dataOutReg     <= overrideMemDataOut[15:8];
              rdLowReg       <= overrideMemDataOut[7:0];
              respPendingReg <= 1'b1;
            end
          end
        end
        TX_WAIT: begin
          if (!byteSending && respPendingReg) begin
            dataOutReg     <= rdLowReg;
            respPendingReg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    overrideMemControl = (stateReg == MEM);
    overrideMemRnW     = !((stateReg == MEM) && isWriteReg);
    overrideMemAddr    = addrReg;
    overrideMemDataIn  = dataReg;
    byteReadyOut       = (stateReg == TX_REQ);
    dataOut            = dataOutReg;
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine with a simple TX responder and a
// 256-word memory model indexed by the low address byte.
module tb_uart_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byteReady = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic        byteReadyOut;
  logic [7:0]  dataOut;
  logic        byteSending = 1'b0;
  logic        overrideMemControl;
  logic        overrideMemRnW;
  logic [15:0] overrideMemAddr;
  logic [15:0] overrideMemDataIn;
  logic [15:0] overrideMemDataOut;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [7:0]  txQ [$];
  int          txCnt = 0;
  int          hsOverlap = 0;
  int          busCycles = 0;
  logic [15:0] lastAddr = '0;
  logic [15:0] lastDataIn = '0;
  logic        lastRnW = 1'b1;

  always #5 clk = ~clk;

  uart_cmd_engine #(.MEM_LATENCY(1), .TIMEOUT(50)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .byteReady(byteReady),
    .dataIn(dataIn),
    .byteReadyOut(byteReadyOut),
    .dataOut(dataOut),
    .byteSending(byteSending),
    .overrideMemControl(overrideMemControl),
    .overrideMemRnW(overrideMemRnW),
    .overrideMemAddr(overrideMemAddr),
    .overrideMemDataIn(overrideMemDataIn),
    .overrideMemDataOut(overrideMemDataOut)
  );

  assign overrideMemDataOut = mem[overrideMemAddr[7:0]];

  // TX responder: accepts a request, stays busy for 4 cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      byteSending <= 1'b0;
      txCnt       <= 0;
    end else if (!byteSending) begin
      if (byteReadyOut) begin
        byteSending <= 1'b1;
        txCnt       <= 4;
        txQ.push_back(dataOut);
      end
    end else begin
      if (byteReadyOut) hsOverlap = hsOverlap + 1;
      if (txCnt == 1) byteSending <= 1'b0;
      txCnt <= txCnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && overrideMemControl) begin
      busCycles  = busCycles + 1;
      lastAddr   = overrideMemAddr;
      lastDataIn = overrideMemDataIn;
      lastRnW    = overrideMemRnW;
      if (!overrideMemRnW) mem[overrideMemAddr[7:0]] = overrideMemDataIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    byteReady = 1'b1;
    dataIn    = b;
    @(posedge clk);
    #1;
    byteReady = 1'b0;
  endtask

  task automatic waitTx(input string tag, input int n);
    int k = 0;
    while (txQ.size() < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, txQ.size(), n);
  endtask

  int base, bus0, hs0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i) ^ 8'hFF};

    // Reset state
    settle(3);
    check("rst_control", overrideMemControl, 1'b0);
    check("rst_rnw", overrideMemRnW, 1'b1);
    check("rst_addr", overrideMemAddr, 16'h0000);
    check("rst_datain", overrideMemDataIn, 16'h0000);
    check("rst_bro", byteReadyOut, 1'b0);
    check("rst_dataout", dataOut, 8'h00);
    rst_n = 1'b1;
    settle(2);
    $display("step: reset released");

    // 1: write
    base = txQ.size(); bus0 = busCycles;
    sendByte(8'h57); sendByte(8'h12); sendByte(8'h34); sendByte(8'hBE); sendByte(8'hEF);
    waitTx("t1_txcount", base + 1);
    settle(10);
    check("t1_buscycles", busCycles - bus0, 2);
    check("t1_rnw", lastRnW, 1'b0);
    check("t1_addr", lastAddr, 16'h1234);
    check("t1_datain", lastDataIn, 16'hBEEF);
    check("t1_resp", txQ[base], 8'h4B);
    check("t1_release", overrideMemControl, 1'b0);
    check("t1_rnw_back", overrideMemRnW, 1'b1);
    $display("step: write 0x1234=0xBEEF done");

    // 2: read back
    base = txQ.size(); bus0 = busCycles; hs0 = hsOverlap;
    sendByte(8'h52); sendByte(8'h12); sendByte(8'h34);
    waitTx("t2_txcount", base + 2);
    settle(10);
    check("t2_buscycles", busCycles - bus0, 2);
    check("t2_rnw", lastRnW, 1'b1);
    check("t2_addr", lastAddr, 16'h1234);
    check("t2_dh", txQ[base], 8'hBE);
    check("t2_dl", txQ[base + 1], 8'hEF);
    check("t2_handshake", hsOverlap - hs0, 2);
    $display("step: read 0x1234 done");

    // 3: junk bytes then link check
    base = txQ.size(); bus0 = busCycles;
    sendByte(8'h00); sendByte(8'h41); sendByte(8'h3F);
    waitTx("t3_txcount", base + 1);
    settle(20);
    check("t3_exact", txQ.size(), base + 1);
    check("t3_resp", txQ[base], 8'h4D);
    check("t3_nobus", busCycles - bus0, 0);
    $display("step: ignore junk, ping done");

    // 4: timeout mid-command, then a clean read
    base = txQ.size(); bus0 = busCycles;
    sendByte(8'h57); sendByte(8'h12);
    settle(60);
    check("t4_nobus", busCycles - bus0, 0);
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h05);
    waitTx("t4_txcount", base + 2);
    settle(10);
    check("t4_rnw", lastRnW, 1'b1);
    check("t4_addr", lastAddr, 16'h0005);
    check("t4_buscycles", busCycles - bus0, 2);
    check("t4_dh", txQ[base], 8'h05);
    check("t4_dl", txQ[base + 1], 8'hFA);
    $display("step: timeout abort then read 0x0005 done");

    // 5: stray byte during TX_WAIT is dropped
    base = txQ.size();
    sendByte(8'h52); sendByte(8'h12); sendByte(8'h34);
    waitTx("t5_first", base + 1);
    settle(1);
    sendByte(8'h3F);
    waitTx("t5_txcount", base + 2);
    settle(30);
    check("t5_exact", txQ.size(), base + 2);
    check("t5_dh", txQ[base], 8'hBE);
    check("t5_dl", txQ[base + 1], 8'hEF);
    sendByte(8'h3F);
    waitTx("t5_ping", base + 3);
    settle(10);
    check("t5_ping_resp", txQ[base + 2], 8'h4D);
    $display("step: stray byte ignored done");

    // 6a: reset during MEM
    base = txQ.size();
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h05);
    check("t6_in_mem", overrideMemControl, 1'b1);
    rst_n = 1'b0;
    settle(1);
    check("t6_mem_control", overrideMemControl, 1'b0);
    check("t6_mem_bro", byteReadyOut, 1'b0);
    rst_n = 1'b1;
    settle(15);
    check("t6_mem_notx", txQ.size(), base);

    // 6b: reset during TX_REQ
    sendByte(8'h3F);
    check("t6_in_txreq", byteReadyOut, 1'b1);
    rst_n = 1'b0;
    settle(1);
    check("t6_tx_bro", byteReadyOut, 1'b0);
    check("t6_tx_control", overrideMemControl, 1'b0);
    rst_n = 1'b1;
    settle(15);
    check("t6_tx_notx", txQ.size(), base);
    sendByte(8'h3F);
    waitTx("t6_ping", base + 1);
    settle(10);
    check("t6_ping_resp", txQ[base], 8'h4D);
    $display("step: reset during MEM and TX_REQ done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
